// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : shared UART types and constants (FSM states, defaults, parity)  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_bit_timer : counts OVERSAMPLE baud ticks, pulses bit_done on the last |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clear,
  input  logic baud_tick,
  output logic bit_done
);

  localparam int c_CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(OVERSAMPLE - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_LAST);
  assign bit_done  = baud_tick && !clear && w_at_last;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (baud_tick) begin
      r_cnt <= w_at_last ? '0 : r_cnt + c_CNT_W'(1);
    end
  end

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_ctrl : UART transmit controller, gates the baud generator and      |
// |                serialises start/data/parity/stop bits onto txd.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 txd,
  output logic                 busy
);

  localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);

  uart_state_e          r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_en, r_par_odd, r_two_stop;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt, w_idx_inc;
  logic                 r_stop_cnt, w_stop_nxt;
  logic                 r_txd, w_txd_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_tx_ready, w_ready_nxt;
  logic                 r_baud_en, w_baud_en_nxt;
  logic                 w_load;
  logic                 w_bit_done;
  logic                 w_parity;
  logic                 w_timer_clear;

  assign tx_ready = r_tx_ready;
  assign baud_en  = r_baud_en;
  assign txd      = r_txd;
  assign busy     = r_busy;

  assign w_idx_inc     = r_idx + c_IDX_W'(1);
  assign w_parity      = (^r_data) ^ (r_par_odd == PAR_ODD);
  assign w_timer_clear = (r_state == IDLE);

  // Timer is held at zero in IDLE so stray ticks cannot pre-advance a frame.
  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (clk),
    .arst_n    (arst_n),
    .clear     (w_timer_clear),
    .baud_tick (baud_tick),
    .bit_done  (w_bit_done)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b1;
      r_baud_en  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_stop_cnt <= w_stop_nxt;
      r_txd      <= w_txd_nxt;
      r_busy     <= w_busy_nxt;
      r_tx_ready <= w_ready_nxt;
      r_baud_en  <= w_baud_en_nxt;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
    end else if (w_load) begin
      r_data     <= tx_data;
      r_par_en   <= parity_en;
      r_par_odd  <= parity_odd;
      r_two_stop <= two_stop;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_stop_nxt    = r_stop_cnt;
    w_txd_nxt     = r_txd;
    w_busy_nxt    = r_busy;
    w_ready_nxt   = r_tx_ready;
    w_baud_en_nxt = r_baud_en;
    w_load        = 1'b0;

    case (r_state)
      IDLE: begin
        if (tx_valid && r_tx_ready) begin
          w_load        = 1'b1;
          w_txd_nxt     = 1'b0;
          w_baud_en_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          w_ready_nxt   = 1'b0;
          w_state_nxt   = START;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_txd_nxt   = r_data[0];
          w_idx_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          if (r_idx != c_LAST_IDX) begin
            w_idx_nxt = w_idx_inc;
            w_txd_nxt = r_data[w_idx_inc];
          end else if (r_par_en) begin
            w_txd_nxt   = w_parity;
            w_state_nxt = PARITY;
          end else begin
            w_txd_nxt   = 1'b1;
            w_stop_nxt  = 1'b0;
            w_state_nxt = STOP;
          end
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_txd_nxt   = 1'b1;
          w_stop_nxt  = 1'b0;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          if (r_two_stop && !r_stop_cnt) begin
            w_stop_nxt = 1'b1;
          end else begin
            w_state_nxt   = IDLE;
            w_baud_en_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            w_ready_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule : uart_tx_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_ctrl : directed bench with a div=1 baud generator model         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx_ctrl;

  localparam int BAUD_DIV = 1;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       force_tick = 1'b0;
  logic       tx_ready, baud_en, txd, busy;
  logic       baud_tick;
  logic [3:0] gen_cnt;
  logic       gen_tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Baud generator: count restarts while disabled, tick is registered.
  always @(posedge clk) begin
    if (!baud_en) begin
      gen_cnt  <= 4'd0;
      gen_tick <= 1'b0;
    end else if (gen_cnt == 4'(BAUD_DIV)) begin
      gen_cnt  <= 4'd0;
      gen_tick <= 1'b1;
    end else begin
      gen_cnt  <= gen_cnt + 4'd1;
      gen_tick <= 1'b0;
    end
  end

  assign baud_tick = gen_tick | force_tick;

  uart_tx_ctrl #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .baud_tick  (baud_tick),
    .baud_en    (baud_en),
    .txd        (txd),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive a character; returns #1 after the accept edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic po,
                      input logic ts, input bit hold);
    tx_data    = d;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    tx_valid   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    parity_en  = ~pe;
    parity_odd = ~po;
    two_stop   = ~ts;
  endtask

  // Called #1 after the accept edge. Start bit spans 33 cycles, others 32.
  task automatic check_frame(input string name, input string exp,
                             input int pulse_at, input int abort_at);
    int n;
    int total;
    int k;
    bit first;
    bit last;
    n     = exp.len();
    total = 33 + 32 * (n - 1);
    for (int rel = 0; rel <= total; rel++) begin
      if (rel == abort_at) begin
        arst_n = 1'b0;
        #1;
        chk({name, " abort txd"}, txd, 1'b1);
        chk({name, " abort baud_en"}, baud_en, 1'b0);
        chk({name, " abort tx_ready"}, tx_ready, 1'b1);
        chk({name, " abort busy"}, busy, 1'b0);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      if (rel == pulse_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      if (pulse_at >= 0 && rel == pulse_at + 1) begin
        tx_valid = 1'b0;
        chk({name, " tx_ready during pulse"}, tx_ready, 1'b0);
      end
      if (rel == total) begin
        chk({name, " end txd"}, txd, 1'b1);
        chk({name, " end baud_en"}, baud_en, 1'b0);
        chk({name, " end busy"}, busy, 1'b0);
        chk({name, " end tx_ready"}, tx_ready, 1'b1);
      end else begin
        k     = (rel < 33) ? 0 : 1 + (rel - 33) / 32;
        first = (rel == 0) || (rel >= 33 && (rel - 33) % 32 == 0);
        last  = (rel == 32) || (rel >= 33 && (rel - 33) % 32 == 31);
        if (first || last)
          chk($sformatf("%s bit%0d %s", name, k, first ? "first" : "last"),
              txd, (exp[k] == "1"));
        if (rel == total - 1) begin
          chk({name, " last cycle baud_en"}, baud_en, 1'b1);
          chk({name, " last cycle busy"}, busy, 1'b1);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #2 arst_n = 1'b0;
    #1;
    chk("reset txd", txd, 1'b1);
    chk("reset tx_ready", tx_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset baud_en", baud_en, 1'b0);
    repeat (3) @(posedge clk);
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("A5_8N1", "0101001011", -1, -1);

    send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    check_frame("07_even", "01110000011", 100, -1);

    send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    check_frame("07_odd", "01110000001", -1, -1);

    send(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check_frame("00_odd", "00000000011", 200, -1);

    send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("3C_2stop", "00011110011", -1, -1);

    // Back-to-back with tx_valid held high across the frame end.
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    tx_data    = 8'hAA;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    check_frame("b2b_55", "0101010101", -1, -1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check_frame("b2b_AA", "0010101011", -1, -1);

    force_tick = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle tick txd c%0d", i), txd, 1'b1);
    end
    force_tick = 1'b0;
    chk("idle tick tx_ready", tx_ready, 1'b1);
    chk("idle tick busy", busy, 1'b0);
    chk("idle tick baud_en", baud_en, 1'b0);
    @(posedge clk);
    #1;

    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("5A_abort", "0010110101", -1, 145);
    @(posedge clk);
    #1;
    send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("81_after_abort", "0100000011", -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d",
             n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_tx_ctrl
`default_nettype wire

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences the shared 16x-oversampling baud generator and serialises one character per frame. It accepts bytes over a valid/ready handshake and enables the baud generator only while a frame is in flight. It counts 16 baud ticks per bit period and drives the serial line with start, data, optional parity and 1 or 2 stop bits. It sits between the host-side TX path and the `txd` pin, with its `baud_en` output wired to the baud generator's `en` input and its `baud_tick` input taken from the generator's tick output.

## Interface
Parameters:
- `DATA_BITS`, default 8: character width, legal values 5–8.
- `OVERSAMPLE`, default 16: baud ticks per bit period.

Ports:
- `clk`  in  1  system clock; one clock domain, all logic on rising edge.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `tx_valid`  in  1  host has a character on `tx_data`.
- `tx_data`  in  `DATA_BITS`  character, sent LSB first.
- `tx_ready`  out  1  controller can accept a character.
- `parity_en`  in  1  insert a parity bit after the data bits.
- `parity_odd`  in  1  parity sense: 1 = odd, 0 = even.
- `two_stop`  in  1  send 2 stop bits; otherwise 1.
- `baud_tick`  in  1  single-cycle tick from the baud generator.
- `baud_en`  out  1  enable for the baud generator.
- `txd`  out  1  serial output; idle level is high.
- `busy`  out  1  frame in progress.

## Operation
- Reset values: `txd`=1, `tx_ready`=1, `busy`=0, `baud_en`=0, FSM=IDLE, tick counter=0, bit index=0.
- FSM states: IDLE → START → DATA → (PARITY if latched parity_en) → STOP → IDLE.
- IDLE:
  - `tx_ready`=1.
  - On `tx_valid && tx_ready`, latch `tx_data`, `parity_en`, `parity_odd` and `two_stop`.
  - On the same edge: `txd`<=0, `baud_en`<=1, `busy`<=1, `tx_ready`<=0, state<=START.
- Bit timing:
  - A 0..OVERSAMPLE-1 tick counter advances only on `baud_tick` while the state is not IDLE.
  - Bit end = `baud_tick` with counter == OVERSAMPLE-1; the counter wraps to 0 on the same edge.
  - Every bit, including each stop bit, lasts exactly OVERSAMPLE ticks.
- START: on bit end, `txd`<=data[0], bit index<=0, go to DATA.
- DATA:
  - On bit end with index < DATA_BITS-1: index++, `txd`<=data[index+1].
  - On bit end at the last index: go to PARITY with `txd`<=parity, or go to STOP with `txd`<=1.
- Parity value = XOR of the latched data bits, inverted when the latched `parity_odd`=1.
- PARITY: on bit end, `txd`<=1, go to STOP.
- STOP:
  - Sends 1 or 2 bit periods of high (a stop counter, reset on entry).
  - On the final bit end: state<=IDLE, `baud_en`<=0, `busy`<=0, `tx_ready`<=1.
- Boundary rules:
  - `baud_tick` while IDLE is ignored.
  - `tx_valid` while busy is ignored; the host holds its data until the handshake completes.
  - Configuration inputs changing mid-frame have no effect until the next accept.
  - Assertion of `arst_n` mid-frame aborts the frame asynchronously: `txd` goes to 1 and `baud_en` to 0 immediately, with no partial stop bit.
  - `tx_valid` held high across a frame end is accepted on the first IDLE cycle, giving a 1-cycle minimum gap between frames plus the generator restart latency.

## Timing
- Accept to falling edge of `txd`: 1 cycle, registered.
- `baud_en` rises on the accept edge and falls on the edge that ends the last stop bit.
- The generator restarts its count from 0 each frame, so the first tick arrives (baud_div+1) cycles after `baud_en` rises, plus the generator's register stage.
- Frame length in ticks: OVERSAMPLE×(1+DATA_BITS+parity_en+1+two_stop).
- With generator divisor D, each bit lasts OVERSAMPLE×(D+1) cycles. The start bit is 1 cycle longer, from the generator register stage.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Default OVERSAMPLE=16 and DATA_BITS=8.
  - Parity-sense constants (PAR_EVEN=0, PAR_ODD=1).
- Sub-module `uart_bit_timer`:
  - The OVERSAMPLE tick counter, with `clear` and `baud_tick` inputs and a single-cycle `bit_done` output.
  - Reused later by the RX controller.
- The baud generator is instantiated beside this block at the UART top level, not inside it.

## Test plan
All scenarios use a real baud generator with baud_div=1 (one tick every 2 cycles), OVERSAMPLE=16, DATA_BITS=8.
- 0xA5, 8N1 → `txd` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 16 ticks; `baud_en` low and `tx_ready` high after the stop bit.
- 0x07, even parity → parity bit 1; 0x07, odd parity → parity bit 0; 0x00, odd parity → parity bit 1.
- 0x3C with `two_stop`=1 → 32 ticks of high after the data bits. Toggling `two_stop` and `parity_en` mid-frame does not change the frame.
- Back-to-back 0x55 then 0xAA with `tx_valid` held high → second start bit begins 1 cycle after the first frame's final stop bit ends; both frames are bit-exact.
- `baud_tick` forced high for 50 cycles while IDLE → `txd` stays 1 and no state change occurs. `tx_valid` pulsed mid-frame → ignored, `tx_ready` stays 0.
- `arst_n` asserted during data bit 3 → `txd`=1, `baud_en`=0, `tx_ready`=1 immediately. The next accepted 0x81 is sent correctly.
